// File: rtl/ps2_rx_key.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, deserialises
// 11-bit frames and folds E0/F0/E1 prefixes into one toggle-strobed key event.
module ps2_rx_key #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 60000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Valid/ready: none. byte_rdy_q and frame_err_q are single-cycle strobes
  // from the frame FSM to the prefix decoder; the wire rate guarantees the
  // decoder consumes each strobe before the next one can occur.

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q, filt_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tout_q;
  logic          byte_rdy_q;
  logic          frame_err_q;

  logic [10:0]   key_q, key_d;
  logic          err_q, err_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;

  // Filtered clock only moves after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q + 8'd1 >= FILT_MAX) begin
        filt_d = clk_s2_q;
        fall_d = ~clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tout_q      <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_q || state_q == IDLE) begin
        tout_q <= '0;
      end else if (tout_q != TOUT_MAX) begin
        tout_q <= tout_q + 1'b1;
      end
      if (fall_q) begin
        case (state_q)
          IDLE: begin
            if (!data_s2_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q   <= {data_s2_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= data_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (data_s2_q && ((^shift_q) ^ par_q)) byte_rdy_q  <= 1'b1;
            else                                   frame_err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE && tout_q == TOUT_MAX) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

  // Prefix decoder; any error also discards half-assembled prefix state.
  always_comb begin
    key_d  = key_q;
    err_d  = frame_err_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    if (frame_err_q) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (byte_rdy_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (shift_q == 8'hE1) begin
        skip_d = 3'd7;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= '0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
    end else begin
      key_q  <= key_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      rel_q  <= rel_d;
      skip_q <= skip_d;
    end
  end

  assign ps2_key = key_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_key.sv
// Bench for ps2_rx_key: table of frames with expected events/errors,
// an event queue checked by a monitor, and hand sequences for corner cases.
module tb_ps2_rx_key;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err;
  logic        busy;

  int          n_vec = 0;
  int          n_miss = 0;
  int          err_cnt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] last_key = '0;
  logic        tog = 1'b0;

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic       evt;
    logic [9:0] key;
    logic       exp_err;
  } vec_t;

  vec_t vecs[27];

  ps2_rx_key #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    pulse_bit(1'b0);
    for (int i = 0; i < 8; i++) pulse_bit(b[i]);
    pulse_bit(bad_par ? (^b) : ~(^b));
    pulse_bit(1'b1);
    wait_cyc(10);
  endtask

  function automatic vec_t mk(input logic [7:0] code, input logic bad, input logic evt,
                              input logic pressed, input logic ext, input logic exp_err);
    vec_t v;
    v.code    = code;
    v.bad     = bad;
    v.evt     = evt;
    v.key     = {pressed, ext, code};
    v.exp_err = exp_err;
    return v;
  endfunction

  // Monitor: every change of ps2_key must match the next queued event.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        last_key = '0;
      end else begin
        if (err) err_cnt++;
        if (ps2_key !== last_key) begin
          if (exp_q.size() == 0) check("unexpected_event", 32'(ps2_key), 32'(last_key));
          else                   check("event", 32'(ps2_key), 32'(exp_q.pop_front()));
          last_key = ps2_key;
        end
      end
    end
  end

  initial begin
    int e0;
    int cyc;
    vecs[0]  = mk(8'h1C, 0, 1, 1, 0, 0);
    vecs[1]  = mk(8'hF0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(8'h1C, 0, 1, 0, 0, 0);
    vecs[3]  = mk(8'hE0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(8'h75, 0, 1, 1, 1, 0);
    vecs[5]  = mk(8'hE0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(8'hF0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(8'h75, 0, 1, 0, 1, 0);
    vecs[8]  = mk(8'h1C, 0, 1, 1, 0, 0);
    vecs[9]  = mk(8'h1C, 1, 0, 0, 0, 1);
    vecs[10] = mk(8'h1C, 0, 1, 1, 0, 0);
    vecs[11] = mk(8'hE1, 0, 0, 0, 0, 0);
    vecs[12] = mk(8'h14, 0, 0, 0, 0, 0);
    vecs[13] = mk(8'h77, 0, 0, 0, 0, 0);
    vecs[14] = mk(8'hE1, 0, 0, 0, 0, 0);
    vecs[15] = mk(8'hF0, 0, 0, 0, 0, 0);
    vecs[16] = mk(8'h14, 0, 0, 0, 0, 0);
    vecs[17] = mk(8'hF0, 0, 0, 0, 0, 0);
    vecs[18] = mk(8'h77, 0, 0, 0, 0, 0);
    vecs[19] = mk(8'h29, 0, 1, 1, 0, 0);
    vecs[20] = mk(8'hF0, 0, 0, 0, 0, 0);
    vecs[21] = mk(8'h1C, 1, 0, 0, 0, 1);
    vecs[22] = mk(8'h1C, 0, 1, 1, 0, 0);
    vecs[23] = mk(8'hE0, 0, 0, 0, 0, 0);
    vecs[24] = mk(8'h1C, 1, 0, 0, 0, 1);
    vecs[25] = mk(8'hAA, 0, 1, 1, 0, 0);
    vecs[26] = mk(8'hFA, 0, 1, 1, 0, 0);

    // Reset state.
    reset_n = 1'b0;
    wait_cyc(3);
    check("reset_key", 32'(ps2_key), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Short clock glitch must not produce a fall (data high would flag err).
    e0 = err_cnt;
    ps2_data = 1'b1;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);

    for (int i = 0; i < 27; i++) begin
      if (vecs[i].evt) begin
        tog = ~tog;
        exp_q.push_back({tog, vecs[i].key});
      end
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].bad);
      check("evt_drained", 32'(exp_q.size()), 32'd0);
      check("frame_err", 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check("frame_busy", 32'(busy), 32'd0);
    end

    // Timeout mid-frame: start bit plus three data bits, then clock idles high.
    e0 = err_cnt;
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    check("timeout_busy_mid", 32'(busy), 32'd1);
    cyc = 0;
    while (busy && cyc < TO + 200) begin
      wait_cyc(1);
      cyc++;
    end
    wait_cyc(5);
    check("timeout_busy_end", 32'(busy), 32'd0);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_no_evt", 32'(exp_q.size()), 32'd0);
    tog = ~tog;
    exp_q.push_back({tog, 1'b1, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0);
    check("after_timeout_evt", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-frame clears outputs at once.
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    check("prereset_busy", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_key", 32'(ps2_key), 32'd0);
    check("midreset_err", 32'(err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    tog = 1'b0;
    wait_cyc(5);
    tog = ~tog;
    exp_q.push_back({tog, 1'b1, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0);
    check("after_reset_evt", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_rx_key.md
# ps2_rx_key

- Receives raw PS/2 keyboard clock/data from the board pins and deserialises frames.
- Folds scan-code prefixes (E0 extended, F0 break, E1 pause) into one event per key.
- Presents each event as the 11-bit toggle-strobed `ps2_key` word that the keyboard matrix block consumes.
- Sits directly upstream of the keyboard matrix; it replaces the HPS-supplied `ps2_key` when a physical PS/2 port is used.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes level (range 2..255).
- TIMEOUT_CYC, 60000: `clk_sys` cycles without a filtered falling edge, mid-frame, before the frame is aborted.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- ps2_key  out  11  event word:
  - [7:0] scan code
  - [8] extended (E0 seen)
  - [9] pressed (1 = make, 0 = break)
  - [10] toggles once per event
- err  out  1  one-cycle pulse on a parity, start, stop or timeout error.
- busy  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. The synchronised clock feeds a filter counter; the filtered level flips only after FILTER_LEN equal samples that differ from the current filtered level. A filtered 1→0 transition produces a one-cycle `fall` pulse. Data is sampled from the synchronised `ps2_data` in the `fall` cycle.
- **Frame FSM:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data = 0 go to DATA with bit count 0; otherwise pulse err and stay in IDLE.
  - DATA: on each `fall`, shift data in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP.
  - STOP: on `fall`, go to IDLE. The frame is valid only if stop = 1 and (XOR of the 8 data bits ^ parity) = 1 (odd parity). A valid frame raises an internal `byte_rdy` for one cycle; an invalid one pulses err.
  - Timeout: a counter resets on every `fall` and counts while state ≠ IDLE. When it reaches TIMEOUT_CYC, return to IDLE, pulse err, and clear all prefix state.
- **Prefix decoder**, on `byte_rdy`:
  - If `skip_cnt` ≠ 0: decrement it and drop the byte.
  - Else, byte E1: set `skip_cnt` = 7 (the pause sequence is swallowed; no event).
  - Else, byte E0: set `ext`.
  - Else, byte F0: set `rel`.
  - Else: emit the event. `ps2_key[7:0]` = byte, `[8]` = ext, `[9]` = ~rel, and `[10]` inverts. Then clear `ext` and `rel`.
- On any err, also clear `ext`, `rel` and `skip_cnt`.
- Bytes AA (BAT OK) and FA (ACK) are emitted like any other byte; filtering them is the consumer's job.

## Timing
- **Reset values:** `ps2_key` = 0, err = 0, busy = 0. The filtered clock resets to 1 and both synchroniser stages to 1. FSM = IDLE; all counters and prefix flags = 0. Reset is effective immediately, including mid-frame; no partial event is ever emitted.
- **Latency:** a raw pin edge produces `fall` 2 cycles (sync) + FILTER_LEN cycles after the pin changes.
- `byte_rdy` is asserted in the cycle after the `fall` that samples the stop bit. `ps2_key` and err are registered and change in the cycle after `byte_rdy`.
- `ps2_key` holds its value between events. Only bit [10] is guaranteed to change per event; two identical events are distinguished solely by the toggle.
- **Simultaneous events:**
  - Timeout and `fall` in the same cycle: `fall` wins and the counter resets.
  - err from a bad frame and a prefix byte cannot coincide, since a bad frame produces no `byte_rdy`.
- **Counter widths:**
  - Timeout counter: ceil(log2(TIMEOUT_CYC+1)) bits; saturates and never wraps.
  - Filter counter: 8 bits.
  - `skip_cnt`: 3 bits.
- **Wire rate:** PS/2 clocks at 10–16.7 kHz (≥ 30 µs per bit). At `clk_sys` ≥ 1 MHz there is no back-pressure; every valid byte is processed before the next can arrive.

## Test plan
- **Make and break:** frame 1C (parity 0, stop 1), then F0, 1C → `ps2_key` = {1,1,0,1C} (toggle 0→1, pressed), then {0,0,0,1C}. No err.
- **Extended:** E0 75, then E0 F0 75 → events {t,1,1,75} and {~t,0,1,75}; `ext` cleared afterwards (a following 1C yields [8] = 0).
- **Parity error:** 1C sent with parity bit 1 → err pulses once, `ps2_key` unchanged. Then a valid 1C → normal make event.
- **Timeout mid-frame:** start bit plus 3 data bits, then the clock held high for TIMEOUT_CYC+10 cycles → err pulse, busy falls, no event. The next full frame decodes correctly.
- **Pause key:** E1 14 77 E1 F0 14 F0 77 → no event, no err. A following 29 → make event for 29.
- **Reset and glitch:** reset_n asserted mid-frame → outputs 0 immediately. A 3-cycle ps2_clk low glitch with FILTER_LEN = 8 → no `fall`, state stays IDLE.
